// File: rtl/file_stream_sequencer.sv
// Walks a run of files through the file-backed line memory and emits each line
// as a registered valid/ready word tagged with last-line / last-file flags.
module file_stream_sequencer #(
   parameter int DATA_W = 25,
   parameter int FILE_W = 10,
   parameter int LINE_W = 6,
   parameter int LINES  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [FILE_W-1:0] first_file,
   input  logic [FILE_W-1:0] num_files,
   output logic              read_file,
   output logic [FILE_W-1:0] file_index,
   output logic [LINE_W-1:0] line_index,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last_line,
   output logic              out_last_file,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] FETCH = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
   localparam logic [FILE_W-1:0] ONE_FILE  = FILE_W'(1);

   logic [1:0]        r_state;
   logic [FILE_W-1:0] r_file_index;
   logic [FILE_W-1:0] r_remaining;
   logic [LINE_W-1:0] r_line_index;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_last_line;
   logic              r_last_file;
   logic              r_done;

   // Handshake: a word transfers on any edge where out_valid && out_ready.
   // A new word may be captured on the same edge the old one is accepted.
   logic w_hs;
   logic w_cap;
   logic w_line_end;

   assign w_hs       = r_out_valid && out_ready;
   assign w_cap      = (r_state == FETCH) && (!r_out_valid || out_ready);
   assign w_line_end = (r_line_index == LAST_LINE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_file_index <= '0;
         r_remaining  <= '0;
         r_line_index <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_last_line  <= 1'b0;
         r_last_file  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_hs) begin
            r_out_valid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (num_files != '0) begin
                     r_file_index <= first_file;
                     r_remaining  <= num_files;
                     r_state      <= LOAD;
                  end else begin
                     r_state <= DRAIN;
                  end
               end
            end
            LOAD: begin
               r_line_index <= '0;
               r_state      <= FETCH;
            end
            FETCH: begin
               if (w_cap) begin
                  r_out_data  <= mem_data;
                  r_out_valid <= 1'b1;
                  r_last_line <= w_line_end;
                  r_last_file <= (r_remaining == ONE_FILE);
                  if (!w_line_end) begin
                     r_line_index <= r_line_index + LINE_W'(1);
                  end else if (r_remaining != ONE_FILE) begin
                     // file_index wraps naturally at 2**FILE_W
                     r_remaining  <= r_remaining - ONE_FILE;
                     r_file_index <= r_file_index + ONE_FILE;
                     r_state      <= LOAD;
                  end else begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!r_out_valid || w_hs) begin
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign read_file     = (r_state == LOAD);
   assign busy          = (r_state != IDLE);
   assign done          = r_done;
   assign file_index    = r_file_index;
   assign line_index    = r_line_index;
   assign out_data      = r_out_data;
   assign out_valid     = r_out_valid;
   assign out_last_line = r_last_line;
   assign out_last_file = r_last_file;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_file_stream_sequencer.sv
// Bench for file_stream_sequencer: a file-backed memory model, a word-level
// scoreboard built from the run parameters, table-driven runs and random runs.
module tb_file_stream_sequencer;

   localparam int DATA_W = 25;
   localparam int FILE_W = 10;
   localparam int LINE_W = 6;
   localparam int LINES  = 64;
   localparam int REC_W  = DATA_W + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic              start = 1'b0;
   logic [FILE_W-1:0] first_file = '0;
   logic [FILE_W-1:0] num_files = '0;
   logic              read_file;
   logic [FILE_W-1:0] file_index;
   logic [LINE_W-1:0] line_index;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              out_last_line;
   logic              out_last_file;
   logic              busy;
   logic              done;
   logic [1:0]        dbg_state;

   file_stream_sequencer #(
      .DATA_W(DATA_W), .FILE_W(FILE_W), .LINE_W(LINE_W), .LINES(LINES)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .first_file(first_file),
      .num_files(num_files), .read_file(read_file), .file_index(file_index),
      .line_index(line_index), .mem_data(mem_data), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last_line(out_last_line),
      .out_last_file(out_last_file), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   // ---------------- memory model ----------------
   function automatic logic [DATA_W-1:0] word_of(input logic [FILE_W-1:0] f,
                                                 input logic [LINE_W-1:0] l);
      return {f, l, 9'(f * 7 + l * 3)};
   endfunction

   logic [FILE_W-1:0] mem_file = '0;
   always @(posedge clk) if (read_file) mem_file <= file_index;
   assign mem_data = word_of(mem_file, line_index);

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
   endtask

   // ---------------- ready driver ----------------
   int rdy_mode = 0;
   int rdy_ph   = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
            rdy_ph++;
         end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- scoreboard / monitor ----------------
   logic [REC_W-1:0]  exp_q[$];
   logic [FILE_W-1:0] read_files[$];
   int n_reads, n_done, n_words, first_read_cyc, last_hs_cyc, done_cyc;
   bit prev_stall = 1'b0;
   logic [REC_W-1:0] held;

   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (read_file) begin
            n_reads++;
            read_files.push_back(file_index);
            if (first_read_cyc < 0) first_read_cyc = cyc;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            check("busy_low_at_done", 64'(busy), 64'd0);
         end
         if (prev_stall && out_valid)
            check("stall_hold", 64'({out_last_file, out_last_line, out_data}), 64'(held));
         if (out_valid && out_ready) begin
            check("q_has_word", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
               check("word", 64'({out_last_file, out_last_line, out_data}), 64'(exp_q.pop_front()));
            n_words++;
            last_hs_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         held = {out_last_file, out_last_line, out_data};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_stats();
      n_reads = 0; n_done = 0; n_words = 0;
      first_read_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
      read_files.delete();
   endtask

   // Reference: a run is the flat sequence of every line of every file in order.
   task automatic build_expect(input int first, input int num);
      exp_q.delete();
      for (int f = 0; f < num; f++)
         for (int l = 0; l < LINES; l++)
            exp_q.push_back({f == num - 1, l == LINES - 1,
                             word_of(FILE_W'(first + f), LINE_W'(l))});
   endtask

   task automatic run(input int first, input int num, input int mode, input bit poke,
                      input int exp_words, input int exp_reads, input int exp_last,
                      input int exp_span);
      rdy_mode = mode;
      clear_stats();
      build_expect(first, num);
      @(negedge clk);
      start = 1'b1; first_file = FILE_W'(first); num_files = FILE_W'(num);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      for (int i = 0; i < 8000 && n_done == 0; i++) begin
         @(negedge clk);
         if (poke && i == 40) begin
            start = 1'b1; first_file = FILE_W'(100); num_files = FILE_W'(5);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("word_count", 64'(n_words), 64'(exp_words));
      check("read_count", 64'(n_reads), 64'(exp_reads));
      check("done_count", 64'(n_done), 64'd1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("idle_after", 64'(busy), 64'd0);
      if (exp_reads > 0 && read_files.size() > 0)
         check("last_file_index", 64'(read_files[read_files.size()-1]), 64'(exp_last));
      if (exp_span > 0)
         check("read_to_last_hs", 64'(last_hs_cyc - first_read_cyc), 64'(exp_span));
      if (num > 0)
         check("done_after_hs", 64'(done_cyc - last_hs_cyc), 64'd1);
   endtask

   typedef struct {
      int first; int num; int mode; bit poke;
      int exp_words; int exp_reads; int exp_last; int exp_span;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{7,    2, 0, 1'b0, 128, 2, 8,    130};
      vecs[1] = '{3,    1, 1, 1'b0, 64,  1, 3,    0};
      vecs[2] = '{1023, 2, 0, 1'b0, 128, 2, 0,    130};
      vecs[3] = '{7,    2, 0, 1'b1, 128, 2, 8,    130};
      vecs[4] = '{0,    0, 0, 1'b0, 0,   0, 0,    0};
      vecs[5] = '{1022, 3, 1, 1'b0, 192, 3, 0,    0};
      vecs[6] = '{200,  1, 2, 1'b0, 64,  1, 200,  0};

      // reset values
      #2;
      check("reset_outputs", 64'({read_file, out_valid, out_last_line, out_last_file, busy,
                                  done, out_data, file_index, line_index}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // reset mid-FETCH: file 3, line 20
      rdy_mode = 0;
      clear_stats();
      build_expect(3, 2);
      @(negedge clk);
      start = 1'b1; first_file = FILE_W'(3); num_files = FILE_W'(2);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && !(dbg_state == 2'd2 && line_index == LINE_W'(20)); i++)
         @(negedge clk);
      check("reached_line20", 64'(line_index), 64'd20);
      rst = 1'b0;
      #1;
      check("async_reset_outputs", 64'({read_file, out_valid, out_last_line, out_last_file, busy,
                                        done, out_data, file_index, line_index}), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("reset_held_outputs", 64'({out_valid, busy, done, file_index, line_index}), 64'd0);
      @(negedge clk);
      check("no_done_after_reset", 64'(n_done), 64'd0);
      exp_q.delete();

      run(5, 1, 0, 1'b0, 64, 1, 5, 65);

      for (int v = 0; v < 7; v++)
         run(vecs[v].first, vecs[v].num, vecs[v].mode, vecs[v].poke,
             vecs[v].exp_words, vecs[v].exp_reads, vecs[v].exp_last, vecs[v].exp_span);

      for (int r = 0; r < 4; r++) begin
         int f, n;
         f = $urandom_range(0, 1023);
         n = $urandom_range(1, 3);
         run(f, n, 2, 1'b0, n * LINES, n, (f + n - 1) % 1024, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/file_stream_sequencer.md
Name: file_stream_sequencer

Overview:
- Drives the file-backed line memory (read_file / file_index / line_index, 25-bit combinational line data back) and turns a run of input files into a valid/ready word stream for the processing core.
- Loads each file in turn, walks lines 0..LINES-1, registers each word, and tags it with last-line and last-file flags.
- Sits directly upstream of the memory's control inputs and downstream of its data output.

Parameters:
DATA_W, 25, width of one line word
FILE_W, 10, width of file_index
LINE_W, 6, width of line_index
LINES, 64, lines per file (must be <= 2**LINE_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
start  in  1  begin a run; sampled only in IDLE
first_file  in  FILE_W  index of first file; captured on accepted start
num_files  in  FILE_W  number of files in run; captured on accepted start; 0 means empty run
read_file  out  1  load strobe to memory; high exactly one cycle per file
file_index  out  FILE_W  file currently loaded or being loaded
line_index  out  LINE_W  line address to memory
mem_data  in  DATA_W  combinational line word from memory, mem[line_index]
out_data  out  DATA_W  registered stream word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid && out_ready
out_last_line  out  1  word is line LINES-1 of its file
out_last_file  out  1  word belongs to the final file of the run
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the run has fully drained

Behaviour:
- Reset values (async, while rst=0): state IDLE; read_file, out_valid, out_last_line, out_last_file, busy, done = 0; out_data, file_index, line_index = 0; internal file counter = 0.
- States: IDLE, LOAD, FETCH, DRAIN.
- IDLE, start=1:
  - num_files != 0: capture file_index <= first_file and remaining <= num_files; go to LOAD.
  - num_files = 0: go to DRAIN. done pulses on the next cycle; read_file never asserts.
- start is ignored in every state except IDLE.
- LOAD:
  - read_file = 1, combinational from state.
  - line_index <= 0.
  - Next state FETCH. Memory contents are valid from the edge that ends LOAD onward.
- FETCH:
  - Capture condition: (!out_valid || out_ready). When it holds, at the edge:
    - out_data <= mem_data and out_valid <= 1.
    - out_last_line <= (line_index == LINES-1).
    - out_last_file <= (remaining == 1).
  - If the captured line is < LINES-1: line_index increments.
  - If the captured line is LINES-1:
    - remaining > 1: remaining decrements, file_index increments (wraps modulo 2**FILE_W, 1023 -> 0), state LOAD.
    - remaining = 1: state DRAIN.
  - If the capture condition does not hold: hold everything.
- Output hold: while out_valid=1 && out_ready=0, out_data and both flags hold stable.
- out_valid clears on a handshake unless a new word is captured in the same edge. Simultaneous handshake and capture is allowed: a full-throughput hand-over.
- The LOAD cycle may overlap a pending output word. This is safe because the word is already registered.
- DRAIN:
  - Wait until out_valid=0, or out_valid && out_ready.
  - At that edge: out_valid <= 0, done <= 1, state IDLE.
  - done is 0 in every other cycle.
- Latency and throughput:
  - start accepted at edge E0; read_file high in cycle E0..E1; first out_valid after edge E2.
  - With out_ready held high: LINES+1 cycles per file, one word per cycle within a file, one bubble per file boundary.
- Reset mid-run: immediate return to the reset values. A partial word is discarded, no done pulse, and the next start begins fresh.
- busy = (state != IDLE). busy stays high through DRAIN and drops in the same cycle done is high.

Test Plan:
- Reset mid-FETCH (file 3, line 20, rst=0 for 2 cycles) -> outputs at reset values immediately; then start first_file=5, num_files=1 -> read_file high one cycle, file_index=5, 64 words = mem[0..63], out_last_line only on the 64th, done one cycle after the final handshake.
- num_files=2, first_file=7, out_ready=1 constant -> read_file pulses twice, file_index 7 then 8, 128 words, 130 cycles from first read_file to the final handshake, out_last_file=1 only on words 65..128, one done pulse.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> out_data stable while stalled, no word lost or duplicated, line order 0..63 preserved.
- first_file=1023, num_files=2 -> second file_index=0, 128 words, done pulse.
- num_files=0 -> no read_file, no out_valid, done pulses exactly once; start pulsed while busy during a 2-file run -> ignored, exactly 128 words.
